// File: rtl/aes_sbox_pkg.sv
// AES S-box lookup tables (forward and inverse), shared by the SubBytes datapath,
// key expansion and the inverse cipher.
package aes_sbox_pkg;

    localparam int AES_BYTE_W = 8;

    function automatic logic [AES_BYTE_W-1:0] fwd_sbox(input logic [AES_BYTE_W-1:0] b);
        logic [AES_BYTE_W-1:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
        return s;
    endfunction

    function automatic logic [AES_BYTE_W-1:0] inv_sbox(input logic [AES_BYTE_W-1:0] b);
        logic [AES_BYTE_W-1:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
            8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
            8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
            8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
            8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
            8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
            8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
            8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
            8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
            8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
            8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
            8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
            8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
            8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
            8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
            8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
            8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
            8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
            8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
            8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
            8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
            8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sub_bytes_pipe_sbox_lane.sv
// One combinational S-box byte lane; the inverse table is only built when INV_EN is set.
module sbox_lane
    import aes_sbox_pkg::*;
#(
    parameter int INV_EN = 1
) (
    input  logic [AES_BYTE_W-1:0] din,
    input  logic                  inv,
    output logic [AES_BYTE_W-1:0] dout
);

    generate
        if (INV_EN != 0) begin : g_inv
            assign dout = inv ? inv_sbox(din) : fwd_sbox(din);
        end else begin : g_fwd
            logic unused_inv;
            assign unused_inv = inv;
            assign dout       = fwd_sbox(din);
        end
    endgenerate

endmodule

// File: rtl/sub_bytes_pipe.sv
// Pipelined AES SubBytes: NUM_BYTES S-box lanes feeding an elastic register pipeline
// with valid/ready flow control and a combinational ready chain (no bubbles when full).
module sub_bytes_pipe
    import aes_sbox_pkg::*;
#(
    parameter int NUM_BYTES   = 16,
    parameter int PIPE_STAGES = 2,
    parameter int INV_EN      = 1,
    parameter int TAG_W       = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [AES_BYTE_W*NUM_BYTES-1:0]   in_data,
    input  logic                              in_inv,
    input  logic [TAG_W-1:0]                  in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [AES_BYTE_W*NUM_BYTES-1:0]   out_data,
    output logic                              out_inv,
    output logic [TAG_W-1:0]                  out_tag,
    output logic                              busy
);

    localparam int DATA_W = AES_BYTE_W * NUM_BYTES;

    logic                   in_inv_eff;
    logic [DATA_W-1:0]      lut_data;

    logic [PIPE_STAGES-1:0] valid_reg;
    logic [DATA_W-1:0]      data_reg [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] inv_reg;
    logic [TAG_W-1:0]       tag_reg  [PIPE_STAGES];

    // Per-stage load sources: stage 0 takes the lookup result, later stages the stage before.
    logic [PIPE_STAGES-1:0] src_valid;
    logic [DATA_W-1:0]      src_data [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] src_inv;
    logic [TAG_W-1:0]       src_tag  [PIPE_STAGES];

    logic [PIPE_STAGES:0]   ready_chain;

    assign in_inv_eff = (INV_EN != 0) && in_inv;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            sbox_lane #(
                .INV_EN (INV_EN)
            ) u_lane (
                .din  (in_data[AES_BYTE_W*gi +: AES_BYTE_W]),
                .inv  (in_inv_eff),
                .dout (lut_data[AES_BYTE_W*gi +: AES_BYTE_W])
            );
        end

        for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign src_valid[gi] = in_valid;
                assign src_data[gi]  = lut_data;
                assign src_inv[gi]   = in_inv_eff;
                assign src_tag[gi]   = in_tag;
            end else begin : g_body
                assign src_valid[gi] = valid_reg[gi-1];
                assign src_data[gi]  = data_reg[gi-1];
                assign src_inv[gi]   = inv_reg[gi-1];
                assign src_tag[gi]   = tag_reg[gi-1];
            end

            // A stage can take new content when empty or when its own content moves on.
            assign ready_chain[gi] = !valid_reg[gi] || ready_chain[gi+1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                    inv_reg[gi]   <= 1'b0;
                    tag_reg[gi]   <= '0;
                end else if (ready_chain[gi]) begin
                    valid_reg[gi] <= src_valid[gi];
                    if (src_valid[gi]) begin
                        data_reg[gi] <= src_data[gi];
                        inv_reg[gi]  <= src_inv[gi];
                        tag_reg[gi]  <= src_tag[gi];
                    end
                end
            end
        end
    endgenerate

    assign ready_chain[PIPE_STAGES] = out_ready;
    assign in_ready                 = ready_chain[0] && rst_n;

    assign out_valid = valid_reg[PIPE_STAGES-1];
    assign out_data  = data_reg[PIPE_STAGES-1];
    assign out_inv   = inv_reg[PIPE_STAGES-1];
    assign out_tag   = tag_reg[PIPE_STAGES-1];
    assign busy      = |valid_reg;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Directed and randomized checks of sub_bytes_pipe against an S-box model built from
// GF(2^8) inversion plus the AES affine map.
module tb_sub_bytes_pipe;

    localparam int NB = 16;
    localparam int PS = 2;
    localparam int TW = 4;
    localparam int DW = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_inv = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_inv;
    logic [TW-1:0] out_tag;
    logic          busy;

    int passed = 0;
    int total  = 0;
    int cycles = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          inv;
        logic [TW-1:0] tag;
    } txn_t;

    txn_t       tx_q[$];
    txn_t       exp_q[$];
    txn_t       obs_q[$];
    logic [7:0] m_fwd [256];
    logic [7:0] m_inv [256];

    always #5 clk = ~clk;

    sub_bytes_pipe #(
        .NUM_BYTES   (NB),
        .PIPE_STAGES (PS),
        .INV_EN      (1),
        .TAG_W       (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_inv   (out_inv),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always @(posedge clk) begin
        cycles <= cycles + 1;
        if (cycles > 90000) begin
            $display("FAIL watchdog: cycles %0d exceeded limit 90000", cycles);
            $fatal(1, "watchdog expired");
        end
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic build_model();
        logic [7:0] b;
        logic [7:0] s;
        for (int v = 0; v < 256; v++) begin
            b = 8'h00;
            for (int w = 1; w < 256; w++)
                if (gf_mul(v[7:0], w[7:0]) == 8'h01) b = w[7:0];
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            m_fwd[v]        = s;
            m_inv[int'(s)]  = v[7:0];
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++)
            r[8*i +: 8] = inv ? m_inv[int'(d[8*i +: 8])] : m_fwd[int'(d[8*i +: 8])];
        return r;
    endfunction

    function automatic logic [DW-1:0] pattern(input int j);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = 8'(j + i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams tx_q through the DUT with random valid/ready; records accepted and emitted txns.
    task automatic run_stream(input int p_valid, input int p_ready, input int stall, input int budget,
                              output int stall_acc, output logic stall_rdy, output int unstable,
                              output int used);
        int   idx;
        int   n;
        int   cyc;
        bit   acc_last;
        bit   hold;
        txn_t held;
        txn_t t;
        idx = 0; n = tx_q.size(); cyc = 0; acc_last = 1'b1; hold = 1'b0;
        stall_acc = 0; stall_rdy = 1'b1; unstable = 0;
        held = '{default: '0};
        obs_q.delete();
        exp_q.delete();
        while (obs_q.size() < n && cyc < budget) begin
            if (!(in_valid && !acc_last))
                in_valid = (idx < n) && ($urandom_range(99) < p_valid);
            if (in_valid) begin
                in_data = tx_q[idx].data;
                in_inv  = tx_q[idx].inv;
                in_tag  = tx_q[idx].tag;
            end
            out_ready = (cyc >= stall) && ($urandom_range(99) < p_ready);
            @(negedge clk);
            if (hold && (!out_valid || out_data !== held.data || out_tag !== held.tag || out_inv !== held.inv))
                unstable++;
            hold      = out_valid && !out_ready;
            held.data = out_data;
            held.inv  = out_inv;
            held.tag  = out_tag;
            if (out_valid && out_ready) obs_q.push_back(held);
            acc_last = in_valid && in_ready;
            if (acc_last) begin
                t.data = model(tx_q[idx].data, tx_q[idx].inv);
                t.inv  = tx_q[idx].inv;
                t.tag  = tx_q[idx].tag;
                exp_q.push_back(t);
                idx++;
                if (cyc < stall) stall_acc++;
            end
            if (cyc == stall - 1) stall_rdy = in_ready;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        used      = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (out_data !== '0 || out_tag !== '0 || out_inv !== 1'b0)
            $display("FAIL reset_outputs: got data %h tag %h inv %b expected zeros", out_data, out_tag, out_inv);
        else passed++;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", in_ready); else passed++;
        tick();
    endtask

    task automatic single_txn(input string name, input logic [DW-1:0] din, input logic inv,
                              input logic [TW-1:0] tag, input logic [DW-1:0] want);
        int n;
        in_data = din; in_inv = inv; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); else passed++;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++; if (n !== PS) $display("FAIL %s_latency: got %0d expected %0d", name, n, PS); else passed++;
        total++; if (out_data !== want) $display("FAIL %s_data: got %h expected %h", name, out_data, want); else passed++;
        total++; if (out_inv !== inv || out_tag !== tag)
            $display("FAIL %s_side: got inv %b tag %h expected inv %b tag %h", name, out_inv, out_tag, inv, tag);
        else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL %s_consumed: got out_valid %b expected 0", name, out_valid); else passed++;
    endtask

    task automatic test_fips_vectors();
        single_txn("fwd_vector", 128'h19a09ae93df4c6f8e3e28d48be2b2a08, 1'b0, 4'h5,
                   128'hd4e0b81e27bfb44111985d52aef1e530);
        single_txn("inv_vector", 128'hd4e0b81e27bfb44111985d52aef1e530, 1'b1, 4'ha,
                   128'h19a09ae93df4c6f8e3e28d48be2b2a08);
    endtask

    task automatic test_exhaustive();
        int          sa;
        logic        sr;
        int          us;
        int          used;
        txn_t        t;
        logic [DW-1:0] fwd_out[256];
        tx_q.delete();
        for (int j = 0; j < 256; j++) begin
            t.data = pattern(j); t.inv = 1'b0; t.tag = 4'(j); tx_q.push_back(t);
            t.inv = 1'b1; tx_q.push_back(t);
        end
        run_stream(100, 100, 0, 1200, sa, sr, us, used);
        total++; if (obs_q.size() !== 512) $display("FAIL exh_count: got %0d expected 512", obs_q.size()); else passed++;
        total++; if (used > 512 + PS + 1) $display("FAIL exh_throughput: got %0d cycles expected <= %0d", used, 512 + PS + 1); else passed++;
        if (obs_q.size() == 512) begin
            for (int k = 0; k < 512; k++) begin
                total++;
                if (obs_q[k].data !== exp_q[k].data || obs_q[k].inv !== exp_q[k].inv || obs_q[k].tag !== exp_q[k].tag)
                    $display("FAIL exh_txn%0d: got %h/%b/%h expected %h/%b/%h", k, obs_q[k].data, obs_q[k].inv,
                             obs_q[k].tag, exp_q[k].data, exp_q[k].inv, exp_q[k].tag);
                else passed++;
            end
            total++; if (obs_q[0].data[7:0] !== 8'h63) $display("FAIL fwd_00: got %h expected 63", obs_q[0].data[7:0]); else passed++;
            total++; if (obs_q[2*8'h53].data[7:0] !== 8'hed) $display("FAIL fwd_53: got %h expected ed", obs_q[2*8'h53].data[7:0]); else passed++;
            total++; if (obs_q[510].data[7:0] !== 8'h16) $display("FAIL fwd_ff: got %h expected 16", obs_q[510].data[7:0]); else passed++;
            total++; if (obs_q[2*8'h63+1].data[7:0] !== 8'h00) $display("FAIL inv_63: got %h expected 00", obs_q[2*8'h63+1].data[7:0]); else passed++;
            total++; if (obs_q[2*8'h16+1].data[7:0] !== 8'hff) $display("FAIL inv_16: got %h expected ff", obs_q[2*8'h16+1].data[7:0]); else passed++;
            for (int j = 0; j < 256; j++) fwd_out[j] = obs_q[2*j].data;
            tx_q.delete();
            for (int j = 0; j < 256; j++) begin
                t.data = fwd_out[j]; t.inv = 1'b1; t.tag = 4'(j); tx_q.push_back(t);
            end
            run_stream(100, 100, 0, 600, sa, sr, us, used);
            total++; if (obs_q.size() !== 256) $display("FAIL roundtrip_count: got %0d expected 256", obs_q.size()); else passed++;
            for (int j = 0; j < obs_q.size(); j++) begin
                total++;
                if (obs_q[j].data !== pattern(j))
                    $display("FAIL roundtrip%0d: got %h expected %h", j, obs_q[j].data, pattern(j));
                else passed++;
            end
        end
    endtask

    task automatic test_back_pressure();
        int   sa;
        logic sr;
        int   us;
        int   used;
        txn_t t;
        tx_q.delete();
        for (int j = 0; j < 5; j++) begin
            t.data = {$urandom, $urandom, $urandom, $urandom}; t.inv = j[0]; t.tag = 4'(j);
            tx_q.push_back(t);
        end
        run_stream(100, 100, 6, 100, sa, sr, us, used);
        total++; if (sa !== PS) $display("FAIL bp_accepts_in_stall: got %0d expected %0d", sa, PS); else passed++;
        total++; if (sr !== 1'b0) $display("FAIL bp_in_ready_full: got %b expected 0", sr); else passed++;
        total++; if (us !== 0) $display("FAIL bp_stability: got %0d changes expected 0", us); else passed++;
        total++; if (obs_q.size() !== 5) $display("FAIL bp_count: got %0d expected 5", obs_q.size()); else passed++;
        for (int k = 0; k < obs_q.size() && k < 5; k++) begin
            total++;
            if (obs_q[k].tag !== 4'(k) || obs_q[k].data !== exp_q[k].data || obs_q[k].inv !== exp_q[k].inv)
                $display("FAIL bp_txn%0d: got tag %h data %h expected tag %h data %h", k, obs_q[k].tag,
                         obs_q[k].data, 4'(k), exp_q[k].data);
            else passed++;
        end
    endtask

    task automatic test_random();
        int   sa;
        logic sr;
        int   us;
        int   used;
        txn_t t;
        tx_q.delete();
        for (int j = 0; j < 10000; j++) begin
            t.data = {$urandom, $urandom, $urandom, $urandom}; t.inv = j[0]; t.tag = 4'($urandom);
            tx_q.push_back(t);
        end
        run_stream(50, 50, 0, 60000, sa, sr, us, used);
        total++; if (obs_q.size() !== 10000) $display("FAIL rand_count: got %0d expected 10000", obs_q.size()); else passed++;
        total++; if (us !== 0) $display("FAIL rand_stability: got %0d changes expected 0", us); else passed++;
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            total++;
            if (obs_q[k].data !== exp_q[k].data || obs_q[k].inv !== exp_q[k].inv || obs_q[k].tag !== exp_q[k].tag)
                $display("FAIL rand_txn%0d: got %h/%b/%h expected %h/%b/%h", k, obs_q[k].data, obs_q[k].inv,
                         obs_q[k].tag, exp_q[k].data, exp_q[k].inv, exp_q[k].tag);
            else passed++;
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = pattern(7); in_inv = 1'b0; in_tag = 4'h1;
        tick();
        in_data = pattern(9); in_tag = 4'h2;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", busy); else passed++;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) $display("FAIL mid_in_ready_rst: got %b expected 0", in_ready); else passed++;
        tick();
        rst_n = 1'b1;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL mid_flush: got busy %b out_valid %b expected 0 0", busy, out_valid);
        else passed++;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
            tick();
        end
        total++; if (stale !== 0) $display("FAIL mid_stale: got %0d stale outputs expected 0", stale); else passed++;
        single_txn("post_reset", pattern(3), 1'b0, 4'h6, model(pattern(3), 1'b0));
    endtask

    initial begin
        build_model();
        test_reset();
        test_fips_vectors();
        test_exhaustive();
        test_back_pressure();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
